adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter BIT_WIDTH, default 8: operand and sum width.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, range 2..16.
REQ-003 Parameter ADDER_LATENCY, default 1: cycles from operand drive to valid sum, range 1..8.
REQ-004 Localparam ID_W = max(1, $clog2(NUM_REQ)).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester operation request.
REQ-008 req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 req_a  in  NUM_REQ*BIT_WIDTH  operand A per requester, slice i = requester i.
REQ-010 req_b  in  NUM_REQ*BIT_WIDTH  operand B per requester.
REQ-011 req_cin  in  NUM_REQ  carry_in per requester.
REQ-012 resp_valid  out  1  result available.
REQ-013 resp_ready  in  1  result consumed.
REQ-014 resp_id  out  ID_W  index of the requester owning the result.
REQ-015 resp_sum  out  BIT_WIDTH  captured sum.
REQ-016 resp_overflow  out  1  captured overflow.
REQ-017 add_n_rst  out  1  active-low reset to the shared adder.
REQ-018 add_a, add_b  out  BIT_WIDTH each  operands to the adder; add_cin  out  1  carry_in to the adder.
REQ-019 add_sum  in  BIT_WIDTH, add_overflow  in  1: adder results.

Function
REQ-020 FSM states IDLE, WAIT, RESP; only IDLE accepts requests.
REQ-021 In IDLE, grant = first asserted req_valid searching from rr_ptr+1 upward, wrapping NUM_REQ-1 -> 0; req_ready[grant]=1 combinationally, all other bits 0.
REQ-022 In WAIT, RESP, or while rst is high, req_ready is all zero.
REQ-023 Accept occurs on the edge where req_valid[g] & req_ready[g]; operands, cin and g are registered, rr_ptr <= g, state -> WAIT, wait counter <= ADDER_LATENCY-1.
REQ-024 add_a/add_b/add_cin are registered outputs, stable from the cycle after accept until return to IDLE.
REQ-025 WAIT decrements the counter each cycle; on the edge with counter==0, add_sum/add_overflow are captured into resp_sum/resp_overflow, resp_id <= g, state -> RESP.
REQ-026 Latency: accept in cycle T gives resp_valid=1 in cycle T+ADDER_LATENCY+1.
REQ-027 In RESP, resp_valid=1 and resp_* hold until resp_ready=1; on that edge state -> IDLE, resp_valid -> 0. If resp_ready is already high on RESP entry, RESP lasts exactly one cycle.
REQ-028 A new accept can occur in the first IDLE cycle after RESP (minimum issue interval ADDER_LATENCY+2 cycles).
REQ-029 req_valid deasserted before its grant has no effect; requesters keep operands stable only until accept.
REQ-030 Result fields stay unchanged in IDLE and WAIT, holding the last response.
REQ-031 Arithmetic is performed entirely by the external adder; the block neither modifies nor checks widths beyond BIT_WIDTH.

Reset
REQ-032 While rst is high: state IDLE, rr_ptr NUM_REQ-1 (requester 0 first), counter 0, resp_valid 0, resp_id 0, resp_sum 0, resp_overflow 0, add_a/add_b/add_cin 0, add_n_rst 0.
REQ-033 add_n_rst rises to 1 on the first clk edge after rst deasserts, and no accept occurs in that first cycle.
REQ-034 A reset during WAIT or RESP abandons the operation; no response for it is ever produced.

Structure
REQ-035 A shared package adder_arb_pkg holds the state enum (IDLE, WAIT, RESP) and the default parameter constants.
REQ-036 Round-robin selection is a sub-module rr_arbiter (inputs req, ptr; outputs grant index and any_req).

Verification (BIT_WIDTH=8, NUM_REQ=4, ADDER_LATENCY=1)
REQ-037 Single request: req 2 with a=0x7F, b=0x01, cin=0 accepted in cycle T -> resp_valid in cycle T+2 with resp_id=2, resp_sum=0x80, and resp_overflow as driven by the adder.
REQ-038 All four requesters valid continuously with resp_ready=1 -> grants in order 0,1,2,3,0 at one accept every 3 cycles.
REQ-039 Backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_* stable, req_ready all 0, completion on the first resp_ready=1 edge.
REQ-040 Wrap: rr_ptr=3 with only req 1 valid -> req 1 granted, and next rr_ptr=1.
REQ-041 rst pulse during WAIT -> no resp_valid afterward; all outputs at reset values; add_n_rst 0 until the first edge after release; the next grant goes to requester 0.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and default parameters for the round-robin adder front end.
// Holds the controller state encoding and the ID width helper.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_BIT_WIDTH     = 8;
  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_ADDER_LATENCY = 1;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted req strictly after ptr, wrapping. Purely combinational,
// zero latency; grant is meaningful only when any_req is high.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  int idx;

  // Scan from farthest to nearest so the nearest hit after ptr is the last one written.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        grant   = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder among NUM_REQ requesters; result appears ADDER_LATENCY+1 cycles
// after accept and is held in RESP until resp_ready, during which no new request is accepted.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int BIT_WIDTH     = DEF_BIT_WIDTH,
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int ADDER_LATENCY = DEF_ADDER_LATENCY,
  localparam int ID_W         = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]           req_cin,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [BIT_WIDTH-1:0]         resp_sum,
  output logic                         resp_overflow,
  output logic                         add_n_rst,
  output logic [BIT_WIDTH-1:0]         add_a,
  output logic [BIT_WIDTH-1:0]         add_b,
  output logic                         add_cin,
  input  logic [BIT_WIDTH-1:0]         add_sum,
  input  logic                         add_overflow
);

  localparam int CNT_W = 3;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic [CNT_W-1:0]  cnt;
  logic              any_req;
  logic              can_accept;
  logic              accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  // add_n_rst gates acceptance so the adder is out of reset before it sees operands.
  assign can_accept = (state == IDLE) && add_n_rst && !rst;
  assign accept     = can_accept && any_req;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // rr_ptr doubles as the owner of the in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      cnt           <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_sum      <= '0;
      resp_overflow <= 1'b0;
      add_a         <= '0;
      add_b         <= '0;
      add_cin       <= 1'b0;
      add_n_rst     <= 1'b0;
    end else begin
      add_n_rst <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            add_a   <= req_a[grant*BIT_WIDTH +: BIT_WIDTH];
            add_b   <= req_b[grant*BIT_WIDTH +: BIT_WIDTH];
            add_cin <= req_cin[grant];
            rr_ptr  <= grant;
            cnt     <= CNT_W'(ADDER_LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            resp_sum      <= add_sum;
            resp_overflow <= add_overflow;
            resp_id       <= rr_ptr;
            resp_valid    <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized directed-sequence bench for adder_arbiter with a behavioural adder and
// a transaction-level model of grant order, latency and result hold.
module tb_adder_arbiter;

  localparam int BW = 8;
  localparam int NR = 4;
  localparam int LAT = 1;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*BW-1:0]  req_a;
  logic [NR*BW-1:0]  req_b;
  logic [NR-1:0]     req_cin;
  logic              resp_valid;
  logic              resp_ready;
  logic [IW-1:0]     resp_id;
  logic [BW-1:0]     resp_sum;
  logic              resp_overflow;
  logic              add_n_rst;
  logic [BW-1:0]     add_a;
  logic [BW-1:0]     add_b;
  logic              add_cin;
  logic [BW-1:0]     add_sum;
  logic              add_overflow;

  always #5 clk = ~clk;

  adder_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .ADDER_LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_cin       (req_cin),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_sum      (resp_sum),
    .resp_overflow (resp_overflow),
    .add_n_rst     (add_n_rst),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_cin       (add_cin),
    .add_sum       (add_sum),
    .add_overflow  (add_overflow)
  );

  // External adder: wrapping sum and two's-complement overflow, held at zero in reset.
  assign add_sum      = add_n_rst ? (add_a + add_b + {7'b0, add_cin}) : '0;
  assign add_overflow = add_n_rst & (add_a[7] == add_b[7]) & (add_sum[7] != add_a[7]);

  int            checks = 0;
  int            failures = 0;
  int            ptr_m;
  logic [BW-1:0] ra [NR];
  logic [BW-1:0] rb [NR];
  logic          rc [NR];
  logic [BW-1:0] last_sum;
  logic          last_ov;
  int            last_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input int ptr, input logic [NR-1:0] m);
    for (int k = 1; k <= NR; k++) begin
      if (m[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*BW +: BW] = ra[i];
      req_b[i*BW +: BW] = rb[i];
      req_cin[i]        = rc[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      ra[i] = BW'($urandom);
      rb[i] = BW'($urandom);
      rc[i] = 1'($urandom);
    end
    pack_ops();
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rvld"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rid"}, 32'(resp_id), 32'd0);
    chk({tag, "_rsum"}, 32'(resp_sum), 32'd0);
    chk({tag, "_rov"}, 32'(resp_overflow), 32'd0);
    chk({tag, "_adda"}, 32'(add_a), 32'd0);
    chk({tag, "_addb"}, 32'(add_b), 32'd0);
    chk({tag, "_addc"}, 32'(add_cin), 32'd0);
    chk({tag, "_nrst"}, 32'(add_n_rst), 32'd0);
  endtask

  // Entered just after a posedge with the DUT in IDLE and operands already driven.
  task automatic txn(input logic [NR-1:0] mask, input int hold, input string tag);
    int            g;
    int            s;
    logic [BW-1:0] ea, eb, es;
    logic          ec, eo;
    req_valid  = mask;
    resp_ready = (hold == 0);
    @(negedge clk);
    g = exp_grant(ptr_m, mask);
    chk({tag, "_grant"}, 32'(req_ready), 32'd1 << g);
    chk({tag, "_idle_rvld"}, 32'(resp_valid), 32'd0);
    chk({tag, "_idle_hold"}, {23'd0, last_ov, last_sum}, {23'd0, resp_overflow, resp_sum});
    ea = ra[g];
    eb = rb[g];
    ec = rc[g];
    es = BW'(int'(ea) + int'(eb) + int'(ec));
    s  = int'($signed(ea)) + int'($signed(eb)) + int'(ec);
    eo = (s > 127) || (s < -128);
    @(posedge clk);
    #1;
    ptr_m = g;
    rand_ops();
    @(negedge clk);
    chk({tag, "_opa"}, 32'(add_a), 32'(ea));
    chk({tag, "_opb"}, 32'(add_b), 32'(eb));
    chk({tag, "_opc"}, 32'(add_cin), 32'(ec));
    chk({tag, "_wait_rvld"}, 32'(resp_valid), 32'd0);
    chk({tag, "_wait_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_rvld"}, 32'(resp_valid), 32'd1);
    chk({tag, "_rid"}, 32'(resp_id), 32'(g));
    chk({tag, "_rsum"}, 32'(resp_sum), 32'(es));
    chk({tag, "_rov"}, 32'(resp_overflow), 32'(eo));
    chk({tag, "_resp_ready"}, 32'(req_ready), 32'd0);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({tag, "_bp_rvld"}, 32'(resp_valid), 32'd1);
      chk({tag, "_bp_res"}, {22'd0, resp_id, resp_overflow, resp_sum}, {22'd0, IW'(g), eo, es});
      chk({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
    end
    if (hold > 0) resp_ready = 1'b1;
    @(posedge clk);
    #1;
    last_sum = es;
    last_ov  = eo;
    last_id  = g;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '1;
    resp_ready = 1'b0;
    rand_ops();
    ptr_m    = NR - 1;
    last_sum = '0;
    last_ov  = 1'b0;
    last_id  = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_chk("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_nrst", 32'(add_n_rst), 32'd0);
    chk("rel_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;

    // All requesters continuously valid: expect 0,1,2,3,0.
    for (int i = 0; i < 5; i++) txn('1, 0, "rr");

    rand_ops();
    ra[2] = 8'h7F;
    rb[2] = 8'h01;
    rc[2] = 1'b0;
    pack_ops();
    txn(4'b0100, 0, "single");
    chk("single_sum_80", 32'(last_sum), 32'h80);

    rand_ops();
    txn(4'b1011, 5, "bp");

    rand_ops();
    txn(4'b1000, 0, "to3");
    rand_ops();
    txn(4'b0010, 0, "wrap");
    rand_ops();
    txn(4'b1111, 0, "afterwrap");

    // Reset during WAIT abandons the operation.
    rand_ops();
    req_valid  = '1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("abort_grant", 32'(req_ready), 32'd1 << exp_grant(ptr_m, '1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    reset_chk("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rel_nrst", 32'(add_n_rst), 32'd0);
    chk("abort_rel_ready", 32'(req_ready), 32'd0);
    chk("abort_rel_rvld", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    ptr_m    = NR - 1;
    last_sum = '0;
    last_ov  = 1'b0;
    last_id  = 0;
    chk("abort_nrst_up", 32'(add_n_rst), 32'd1);
    rand_ops();
    txn('1, 0, "post_abort");

    for (int i = 0; i < 12; i++) begin
      logic [NR-1:0] m;
      m = NR'($urandom_range(1, 15));
      rand_ops();
      txn(m, int'($urandom_range(0, 3)), "rand");
    end

    req_valid = '0;
    @(negedge clk);
    chk("end_rvld", 32'(resp_valid), 32'd0);
    chk("end_hold", {22'd0, resp_id, resp_overflow, resp_sum}, {22'd0, IW'(last_id), last_ov, last_sum});
    chk("end_ready", 32'(req_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
